eval_arbiter: RTL and testbench
===============================

// Module: eval_arbiter
// PURPOSE
//  Round-robin scheduler sharing one two-step pass/fail evaluator (inputs present/check, registered
//  2-bit code 00 idle, 01 advancing, 10 rejected, 11 approved) among NREQ inspection stations.
//  Grants one station, sequences arm/check1/check2, captures verdict or times out, returns result.
//  Sits between station request lines and the evaluator; evaluator code feeds back to ev_code.
// PARAMETERS
//  NREQ     4   number of requesting stations (2..8)
//  TIMEOUT  15  max cycles waiting for a final code (10/11) after last check; 4-bit counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       reset, asynchronous, active-high (rst_n=1 resets)
//  req        in   NREQ    station i requests evaluation; level, held until done for i
//  req_bits   in   2*NREQ  {bit1,bit0} per station i at [2i+1:2i]; sampled at grant
//  ev_present out  1       to evaluator presence input
//  ev_check   out  1       to evaluator check input
//  ev_code    in   2       evaluator registered code
//  gnt        out  NREQ    one-hot grant, held IDLE-exit..DONE inclusive
//  done       out  1       one-cycle pulse, verdict valid for granted station
//  verdict    out  2       10 reject, 11 approve, 00 timeout/error; held until next done
//  busy       out  1       high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, gnt=0, done=0, verdict=00, ev_present=0, ev_check=0, busy=0, rr_ptr=0.
//  All outputs registered (1-cycle latency from state decision).
//  IDLE : if |req, pick first set bit at/after rr_ptr (wrap); latch index, bits; gnt, -> ARM.
//  ARM  : present=1,check=0 one cycle (evaluator S0->advancing) -> CHK1.
//  CHK1 : present=1,check=bit0 -> CHK2.
//  CHK2 : if ev_code==10 (early reject) -> DONE verdict 10, present=0;
//         else present=1,check=bit1 -> WAIT, timer cleared.
//  WAIT : present=0. ev_code 10/11 -> DONE verdict=ev_code; else timer++; timer==TIMEOUT ->
//         DONE verdict 00.
//  DONE : done=1 one cycle, gnt dropped next cycle, rr_ptr=granted index+1 mod NREQ -> IDLE.
//  Minimum transaction: IDLE..DONE = 5 cycles when verdict arrives first WAIT cycle.
//  Requester drops req mid-transaction: ignored; transaction completes, done still pulses.
//  req for granted station still high after DONE: eligible again only after others (RR fairness).
//  Simultaneous req: lowest index at/after rr_ptr wins; no starvation, worst-case wait NREQ-1 txns.
//  ev_code 01 in WAIT: keep waiting. Unexpected 10/11 in ARM/CHK1: ignored (evaluator settling).
//  Reset asserted mid-transaction: immediate return to reset values; evaluator sees present=0.
// CONFIGURATION
//  STATS_EN defined: per-station 8-bit saturating approve/reject counters; extra ports
//   stat_sel in clog2(NREQ), stat_approve out 8, stat_reject out 8 (combinational read of
//   selected station); counters update on DONE, saturate at 255, clear on reset. Timeouts not
//   counted.
//  STATS_EN undefined: no counters, no extra ports; core behaviour identical.
// STRUCTURE
//  Package eval_pkg: state enum (IDLE,ARM,CHK1,CHK2,WAIT,DONE), code constants CODE_IDLE=00,
//   CODE_ADV=01, CODE_REJ=10, CODE_APP=11, TIMER_W=4.
//  Sub-module rr_pick: combinational round-robin priority select (req, rr_ptr -> idx, valid).
//  Top holds FSM, timer, latches, optional stats.
// TESTING
//  Bench models evaluator as registered Moore FSM (1-cycle code latency).
//  1 req=0001,bits=11 -> gnt=0001, ARM/CHK1/CHK2 present=1, done at cycle 5, verdict=11.
//  2 req=0010,bits=01 -> reject after check2, verdict=10; bits=00 -> early reject in CHK2, 10.
//  3 req=1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; each done pulse exactly once per txn.
//  4 evaluator stuck at 01 -> done after TIMEOUT=15 WAIT cycles, verdict=00.
//  5 rst_n=1 during CHK1 -> same cycle gnt=0,present=0,busy=0; after release, fresh grant from 0.
//  6 STATS_EN: 300 approves on station 2 -> stat_approve=255 at stat_sel=2, stat_reject=0.

Source files
------------

// File: rtl/eval_pkg.sv
// Shared types and constants for the evaluator arbiter: FSM states, evaluator codes, timer width.
package eval_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    CHK1 = 3'd2,
    CHK2 = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] CODE_IDLE = 2'b00;
  localparam logic [1:0] CODE_ADV  = 2'b01;
  localparam logic [1:0] CODE_REJ  = 2'b10;
  localparam logic [1:0] CODE_APP  = 2'b11;

  localparam int TIMER_W = 4;

  // Both final codes (reject/approve) have the upper bit set.
  function automatic logic is_final(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first asserted request at or after rr_ptr, wrapping at NREQ.
module rr_pick #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W:0] pos;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NREQ)) pos = pos - (IDX_W+1)'(NREQ);
      if (!valid && req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/eval_arbiter.sv
// Round-robin arbiter sharing one two-step evaluator among NREQ stations.
// Optional STATS_EN adds per-station saturating approve/reject counters.
//
// state | meaning
// IDLE  | no transaction; pick next requester round-robin
// ARM   | present=1, check=0: evaluator arms
// CHK1  | present=1, check=bit0
// CHK2  | early reject if code is 10, else present=1, check=bit1
// WAIT  | present=0, wait for final code or timeout
// DONE  | done pulse, verdict valid, advance rr pointer
module eval_arbiter
  import eval_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 15,
  localparam int IDX_W   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_bits,
  output logic              ev_present,
  output logic              ev_check,
  input  logic [1:0]        ev_code,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic [1:0]        verdict,
  output logic              busy
`ifdef STATS_EN
  ,
  input  logic [IDX_W-1:0]  stat_sel,
  output logic [7:0]        stat_approve,
  output logic [7:0]        stat_reject
`endif
);

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_n;
  logic [1:0]           bits_q, bits_n;
  logic [TIMER_W-1:0]   timer_q, timer_n;
  logic [1:0]           verdict_n;
  logic [NREQ-1:0]      gnt_n;
  logic                 present_n, check_n, done_n, busy_n;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    rr_ptr_n  = rr_ptr_q;
    bits_n    = bits_q;
    timer_n   = timer_q;
    verdict_n = verdict;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_n   = pick_idx;
          bits_n  = req_bits[{pick_idx, 1'b0} +: 2];
          state_n = ARM;
        end
      end
      ARM:  state_n = CHK1;
      CHK1: state_n = CHK2;
      CHK2: begin
        if (ev_code == CODE_REJ) begin
          verdict_n = CODE_REJ;
          state_n   = DONE;
        end else begin
          timer_n = TIMER_W'(TIMEOUT - 1);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (is_final(ev_code)) begin
          verdict_n = ev_code;
          state_n   = DONE;
        end else if (timer_q == '0) begin
          verdict_n = CODE_IDLE;
          state_n   = DONE;
        end else begin
          timer_n = timer_q - TIMER_W'(1);
        end
      end
      DONE: begin
        rr_ptr_n = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next-state decision so they line up with the state.
    present_n = (state_n == ARM) || (state_n == CHK1) || (state_n == CHK2);
    check_n   = 1'b0;
    if (state_n == CHK1) check_n = bits_n[0];
    if (state_n == CHK2) check_n = bits_n[1];
    done_n = (state_n == DONE);
    busy_n = (state_n != IDLE);
    gnt_n  = (state_n == IDLE) ? '0 : (NREQ'(1) << idx_n);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      bits_q     <= '0;
      timer_q    <= '0;
      verdict    <= CODE_IDLE;
      gnt        <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      ev_present <= 1'b0;
      ev_check   <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      rr_ptr_q   <= rr_ptr_n;
      bits_q     <= bits_n;
      timer_q    <= timer_n;
      verdict    <= verdict_n;
      gnt        <= gnt_n;
      done       <= done_n;
      busy       <= busy_n;
      ev_present <= present_n;
      ev_check   <= check_n;
    end
  end

`ifdef STATS_EN
  logic [7:0] app_cnt [NREQ];
  logic [7:0] rej_cnt [NREQ];

  // Verdict register is stable during DONE; timeouts (00) are not counted.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        app_cnt[i] <= '0;
        rej_cnt[i] <= '0;
      end
    end else if (state_q == DONE) begin
      if (verdict == CODE_APP && app_cnt[idx_q] != 8'hFF)
        app_cnt[idx_q] <= app_cnt[idx_q] + 8'd1;
      if (verdict == CODE_REJ && rej_cnt[idx_q] != 8'hFF)
        rej_cnt[idx_q] <= rej_cnt[idx_q] + 8'd1;
    end
  end

  assign stat_approve = app_cnt[stat_sel];
  assign stat_reject  = rej_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_eval_arbiter.sv
// Self-checking bench for eval_arbiter with a registered Moore evaluator model.
module tb_eval_arbiter;
  import eval_pkg::*;

  localparam int NREQ = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] req_bits = '0;
  logic       ev_present, ev_check;
  logic [1:0] ev_code;
  logic [3:0] gnt;
  logic       done;
  logic [1:0] verdict;
  logic       busy;
`ifdef STATS_EN
  logic [1:0] stat_sel = '0;
  logic [7:0] stat_approve, stat_reject;
`endif

  int   checks = 0;
  int   failures = 0;
  logic ev_stuck = 1'b0;
  int   ev_stage;

  always #5 clk = ~clk;

  eval_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_bits   (req_bits),
    .ev_present (ev_present),
    .ev_check   (ev_check),
    .ev_code    (ev_code),
    .gnt        (gnt),
    .done       (done),
    .verdict    (verdict),
    .busy       (busy)
`ifdef STATS_EN
    ,
    .stat_sel     (stat_sel),
    .stat_approve (stat_approve),
    .stat_reject  (stat_reject)
`endif
  );

  // Evaluator: arm on first present cycle, then two checks; any failed check rejects.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ev_code  <= CODE_IDLE;
      ev_stage <= 0;
    end else if (ev_stuck) begin
      ev_code  <= CODE_ADV;
      ev_stage <= 0;
    end else if (!ev_present) begin
      ev_code  <= CODE_IDLE;
      ev_stage <= 0;
    end else begin
      case (ev_stage)
        0: begin ev_code <= CODE_ADV; ev_stage <= 1; end
        1: begin
          if (ev_check) begin ev_code <= CODE_ADV; ev_stage <= 2; end
          else begin ev_code <= CODE_REJ; ev_stage <= 3; end
        end
        2: begin ev_code <= ev_check ? CODE_APP : CODE_REJ; ev_stage <= 3; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < limit);
    chk("done_within_bound", done, 1);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [7:0] bits;
    logic       stuck;
    logic       drop;
    logic [3:0] gnt;
    logic [1:0] verdict;
    int         cyc;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] rr_exp[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    logic got;
    logic prev_done;

    // rr_ptr evolves across rows: 0,1,2,2,3,0,2,0,1,3
    vecs[0] = '{4'b0001, 8'h03, 1'b0, 1'b0, 4'b0001, CODE_APP,  5};
    vecs[1] = '{4'b0010, 8'h04, 1'b0, 1'b0, 4'b0010, CODE_REJ,  5};
    vecs[2] = '{4'b0010, 8'h00, 1'b0, 1'b0, 4'b0010, CODE_REJ,  4};
    vecs[3] = '{4'b0100, 8'h20, 1'b0, 1'b0, 4'b0100, CODE_REJ,  4};
    vecs[4] = '{4'b1000, 8'hC0, 1'b1, 1'b0, 4'b1000, CODE_IDLE, 19};
    vecs[5] = '{4'b1010, 8'hFF, 1'b0, 1'b0, 4'b0010, CODE_APP,  5};
    vecs[6] = '{4'b1001, 8'hFF, 1'b0, 1'b0, 4'b1000, CODE_APP,  5};
    vecs[7] = '{4'b0001, 8'h03, 1'b0, 1'b0, 4'b0001, CODE_APP,  5};
    vecs[8] = '{4'b0101, 8'hFF, 1'b0, 1'b0, 4'b0100, CODE_APP,  5};
    vecs[9] = '{4'b0001, 8'h03, 1'b0, 1'b1, 4'b0001, CODE_APP,  5};
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {gnt, done, verdict, ev_present, ev_check, busy}, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      req      = vecs[v].req;
      req_bits = vecs[v].bits;
      ev_stuck = vecs[v].stuck;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
        step();
        cyc++;
        if (cyc == 1) begin
          chk("arm_busy_present_check", {busy, ev_present, ev_check}, 3'b110);
          if (vecs[v].drop) req = '0;
        end
        if (done) got = 1'b1;
      end
      chk("done_seen", got, 1);
      chk("done_cycle", cyc, vecs[v].cyc);
      chk("gnt_at_done", gnt, vecs[v].gnt);
      chk("verdict", verdict, vecs[v].verdict);
      req = '0;
      ev_stuck = 1'b0;
      step();
      chk("after_done_idle", {gnt, done, busy}, 0);
      chk("verdict_held", verdict, vecs[v].verdict);
    end

    // Round-robin with all requests held from a fresh reset.
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'hF;
    req_bits = 8'hFF;
    n = 0;
    cyc = 0;
    prev_done = 1'b0;
    while (n < 5 && cyc < 60) begin
      step();
      cyc++;
      if (done) begin
        chk("rr_grant_order", gnt, rr_exp[n]);
        chk("rr_single_pulse", prev_done, 0);
        n++;
        if (n == 5) req = '0;
      end
      prev_done = done;
    end
    chk("rr_txn_count", n, 5);
    step();
    step();

    // Reset mid-transaction, after rr_ptr has moved away from 0.
    req = 4'b0010;
    wait_done(20, cyc);
    req = 4'b0100;
    step();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("chk1_present", {ev_present, gnt}, 5'b10100);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_txn", {gnt, ev_present, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'hF;
    step();
    chk("rst_fresh_grant", gnt, 4'b0001);
    wait_done(20, cyc);
    chk("rst_fresh_verdict", verdict, CODE_APP);
    req = '0;
    step();

`ifdef STATS_EN
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0100;
    req_bits = 8'hFF;
    n = 0;
    cyc = 0;
    while (n < 300 && cyc < 2500) begin
      step();
      cyc++;
      if (done) begin
        n++;
        if (n == 300) req = '0;
      end
    end
    chk("stats_txn_count", n, 300);
    step();
    step();
    stat_sel = 2'd2;
    #1;
    chk("stat_approve_sat", stat_approve, 8'd255);
    chk("stat_reject_zero", stat_reject, 8'd0);
    stat_sel = 2'd0;
    #1;
    chk("stat_other_station", stat_approve, 8'd0);
    @(negedge clk);
    req = 4'b0100;
    req_bits = 8'h00;
    wait_done(20, cyc);
    req = '0;
    step();
    stat_sel = 2'd2;
    #1;
    chk("stat_reject_one", stat_reject, 8'd1);
    chk("stat_approve_hold", stat_approve, 8'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
